// File: rtl/ex_muldiv.sv
// ex_muldiv: EX-stage multiply/divide unit owning the architectural HI/LO pair.
//   MULT/MULTU write the 64-bit product to {HI,LO} in a single cycle.
//   DIV/DIVU run a 32-step restoring divider and stall the front end.
//   MTHI/MTLO copy rs_data_i into the selected register.
// Ports:
//   clk         rising-edge clock
//   rst         synchronous active-low reset
//   aluop_i     EX-stage opcode from the ID/EX register
//   rs_data_i   dividend / multiplicand / MTHI-MTLO source
//   rt_data_i   divisor / multiplier
//   annul_i     flush of the instruction currently in EX
//   stall_o     hold request for the IF/ID/EX pipeline registers
//   div_busy_o  high while the divider is iterating
//   hi_o, lo_o  architectural HI / LO registers
module ex_muldiv #(
  parameter logic [7:0] AOP_MULT  = 8'h18,
  parameter logic [7:0] AOP_MULTU = 8'h19,
  parameter logic [7:0] AOP_DIV   = 8'h1A,
  parameter logic [7:0] AOP_DIVU  = 8'h1B,
  parameter logic [7:0] AOP_MTHI  = 8'h11,
  parameter logic [7:0] AOP_MTLO  = 8'h13
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [7:0]  aluop_i,
  input  logic [31:0] rs_data_i,
  input  logic [31:0] rt_data_i,
  input  logic        annul_i,
  output logic        stall_o,
  output logic        div_busy_o,
  output logic [31:0] hi_o,
  output logic [31:0] lo_o
);

  localparam int DATA_W = 32;

  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] BUSY = 2'd1;
  localparam logic [1:0] DONE = 2'd2;

  logic [1:0]        state;
  logic [4:0]        step_cnt;
  logic [DATA_W-1:0] quo_q;   // dividend shifts out, quotient bits shift in
  logic [DATA_W-1:0] dsr_q;
  logic [DATA_W-1:0] rem_q;
  logic              q_neg;
  logic              r_neg;
  logic [DATA_W-1:0] hi_q;
  logic [DATA_W-1:0] lo_q;

  // Two's-complement negate when neg is set; used for both operand
  // magnitudes and the final sign correction.
  function automatic logic [DATA_W-1:0] apply_sign(input logic [DATA_W-1:0] mag,
                                                   input logic              neg);
    return neg ? (~mag + DATA_W'(1)) : mag;
  endfunction

  logic                       is_mult, is_multu, is_div, is_divu, is_mthi, is_mtlo;
  logic                       div_req;
  logic signed [2*DATA_W-1:0] rs_sx, rt_sx, prod_s;
  logic [2*DATA_W-1:0]        prod_u;
  logic [DATA_W-1:0]          rs_mag, rt_mag;
  logic [DATA_W:0]            rem_shift, rem_diff;
  logic                       borrow;
  logic [DATA_W-1:0]          rem_next;

  always_comb begin
    is_mult  = (aluop_i == AOP_MULT);
    is_multu = (aluop_i == AOP_MULTU);
    is_div   = (aluop_i == AOP_DIV);
    is_divu  = (aluop_i == AOP_DIVU);
    is_mthi  = (aluop_i == AOP_MTHI);
    is_mtlo  = (aluop_i == AOP_MTLO);
    div_req  = (state == IDLE) && (is_div || is_divu);

    rs_sx  = {{DATA_W{rs_data_i[DATA_W-1]}}, rs_data_i};
    rt_sx  = {{DATA_W{rt_data_i[DATA_W-1]}}, rt_data_i};
    prod_s = rs_sx * rt_sx;
    prod_u = {{DATA_W{1'b0}}, rs_data_i} * {{DATA_W{1'b0}}, rt_data_i};

    // 32'h80000000 has no positive signed form but its unsigned magnitude
    // is exact, so the divider core stays purely unsigned.
    rs_mag = apply_sign(rs_data_i, is_div && rs_data_i[DATA_W-1]);
    rt_mag = apply_sign(rt_data_i, is_div && rt_data_i[DATA_W-1]);

    // Restoring step: the partial remainder is always below the divisor, so
    // the shifted value fits DATA_W+1 bits and bit DATA_W of the difference
    // is a clean borrow flag.
    rem_shift = {rem_q, quo_q[DATA_W-1]};
    rem_diff  = rem_shift - {1'b0, dsr_q};
    borrow    = rem_diff[DATA_W];
    rem_next  = borrow ? rem_shift[DATA_W-1:0] : rem_diff[DATA_W-1:0];
  end

  assign stall_o    = !annul_i && (div_req || (state == BUSY));
  assign div_busy_o = (state == BUSY);
  assign hi_o       = hi_q;
  assign lo_o       = lo_q;

  always_ff @(posedge clk) begin
    if (!rst) begin
      state    <= IDLE;
      step_cnt <= 5'd0;
      quo_q    <= '0;
      dsr_q    <= '0;
      rem_q    <= '0;
      q_neg    <= 1'b0;
      r_neg    <= 1'b0;
      hi_q     <= '0;
      lo_q     <= '0;
    end else if (annul_i) begin
      state <= IDLE;
    end else begin
      case (state)
        IDLE: begin
          if (is_mult) begin
            {hi_q, lo_q} <= $unsigned(prod_s);
          end else if (is_multu) begin
            {hi_q, lo_q} <= prod_u;
          end else if (is_mthi) begin
            hi_q <= rs_data_i;
          end else if (is_mtlo) begin
            lo_q <= rs_data_i;
          end else if (is_div || is_divu) begin
            if (rt_data_i != '0) begin
              quo_q    <= rs_mag;
              dsr_q    <= rt_mag;
              rem_q    <= '0;
              step_cnt <= 5'd0;
              q_neg    <= is_div && (rs_data_i[DATA_W-1] ^ rt_data_i[DATA_W-1]);
              r_neg    <= is_div && rs_data_i[DATA_W-1];
              state    <= BUSY;
            end else begin
              // Divide by zero: fixed result, no iteration, no sign fix-up.
              quo_q <= '1;
              rem_q <= rs_data_i;
              q_neg <= 1'b0;
              r_neg <= 1'b0;
              state <= DONE;
            end
          end
        end
        BUSY: begin
          quo_q    <= {quo_q[DATA_W-2:0], ~borrow};
          rem_q    <= rem_next;
          step_cnt <= step_cnt + 5'd1;
          if (step_cnt == 5'd31) begin
            state <= DONE;
          end
        end
        DONE: begin
          lo_q  <= apply_sign(quo_q, q_neg);
          hi_q  <= apply_sign(rem_q, r_neg);
          state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: doc/ex_muldiv.md
EX_MULDIV -- requirements
Module: ex_muldiv

Interface
REQ-001 SHALL provide one clock and a reset that is synchronous and active-low.
REQ-002 SHALL have parameter AOP_MULT, default 8'h18, signed 32x32 multiply opcode.
REQ-003 SHALL have parameter AOP_MULTU, default 8'h19, unsigned multiply opcode.
REQ-004 SHALL have parameter AOP_DIV, default 8'h1A, signed divide opcode.
REQ-005 SHALL have parameter AOP_DIVU, default 8'h1B, unsigned divide opcode.
REQ-006 SHALL have parameter AOP_MTHI, default 8'h11, write rs_data_i to HI.
REQ-007 SHALL have parameter AOP_MTLO, default 8'h13, write rs_data_i to LO.
REQ-008 SHALL have port clk, input, 1, rising-edge clock.
REQ-009 SHALL have port rst, input, 1, synchronous active-low reset.
REQ-010 SHALL have port aluop_i, input, 8, EX-stage opcode from the ID/EX register.
REQ-011 SHALL have port rs_data_i, input, 32, dividend / multiplicand / MTHI-MTLO source.
REQ-012 SHALL have port rt_data_i, input, 32, divisor / multiplier.
REQ-013 SHALL have port annul_i, input, 1, flush of the instruction currently in EX.
REQ-014 SHALL have port stall_o, output, 1, request to hold IF/ID/EX pipeline registers.
REQ-015 SHALL have port div_busy_o, output, 1, high while state is BUSY.
REQ-016 SHALL have port hi_o, output, 32, architectural HI register.
REQ-017 SHALL have port lo_o, output, 32, architectural LO register.

Function
REQ-018 SHALL implement states IDLE, BUSY, DONE; reset state IDLE.
REQ-019 SHALL, in IDLE with annul_i=0, write {HI,LO} <= 64-bit product at the next edge for MULT/MULTU; stall_o=0; state stays IDLE.
REQ-020 SHALL, in IDLE with annul_i=0 and MTHI/MTLO, update only the selected register at the next edge; stall_o=0.
REQ-021 SHALL, in IDLE with annul_i=0 and DIV/DIVU, drive stall_o=1 combinationally in that cycle.
REQ-022 SHALL, on DIV/DIVU with rt_data_i!=0, latch operands (absolute values for DIV, raw for DIVU) and the two sign bits, clear a 5-bit step counter, and enter BUSY.
REQ-023 SHALL, on DIV/DIVU with rt_data_i==0, enter DONE directly with quotient 32'hFFFFFFFF and remainder = rs_data_i.
REQ-024 SHALL, in BUSY, perform one restoring shift-subtract step per cycle, 32 steps total, with stall_o=1 and div_busy_o=1.
REQ-025 SHALL leave BUSY for DONE after the step where counter==31; counter wraps to 0 and is not otherwise used.
REQ-026 SHALL, for DIV, negate the quotient when operand signs differ and give the remainder the dividend's sign.
REQ-027 SHALL produce quotient 32'h80000000, remainder 0 for DIV 32'h80000000 / 32'hFFFFFFFF.
REQ-028 SHALL, in DONE, drive stall_o=0, write LO<=quotient and HI<=remainder at the edge, and return to IDLE.
REQ-029 SHALL keep divide latency fixed: 33 cycles with stall_o=1, then 1 DONE cycle; divide-by-zero gives 1 stall cycle, then DONE.
REQ-030 SHALL ignore aluop_i while in BUSY or DONE.
REQ-031 SHALL, when annul_i=1 in any state, return to IDLE at the next edge with HI/LO unchanged and stall_o=0 combinationally.
REQ-032 SHALL leave HI/LO unchanged for all other opcodes.

Reset
REQ-033 SHALL, while rst=0 at an edge, set state=IDLE, counter=0, hi_o=0, lo_o=0, and internal operand and remainder registers to 0.
REQ-034 SHALL drive stall_o=0 and div_busy_o=0 while state=IDLE and no divide is presented.
REQ-035 SHALL abort a divide on reset mid-BUSY; no HI/LO write occurs.

Verification
REQ-036 SHALL test MULT with rs=32'hFFFFFFFE, rt=3 -> HI=32'hFFFFFFFF, LO=32'hFFFFFFFA after 1 edge; MULTU with the same operands -> HI=2, LO=32'hFFFFFFFA.
REQ-037 SHALL test DIV with rs=-7, rt=2 -> stall_o high 33 cycles, then LO=32'hFFFFFFFD, HI=32'hFFFFFFFF at the DONE edge.
REQ-038 SHALL test DIVU with rs=100, rt=7 -> LO=14, HI=2; DIVU with rs=5, rt=0 -> 1 stall cycle, then LO=32'hFFFFFFFF, HI=5.
REQ-039 SHALL test DIV 32'h80000000 / -1 -> LO=32'h80000000, HI=0.
REQ-040 SHALL test annul_i=1 at BUSY step 10 -> IDLE at the next edge, stall_o=0, HI/LO keep prior values.
REQ-041 SHALL test rst=0 at BUSY step 20 after MTHI 32'h1234 -> state IDLE, hi_o=0, lo_o=0; a following DIVU runs a full 33-cycle stall.
